uart_rx: RTL and testbench

Serial receiver for the UART link, running on the same 16x-oversampled UART clock as the transmitter. Each frame is one start bit, eight data bits LSB first, one parity bit and one stop bit, each 16 clocks wide. The block sits between the RX pin and the user logic. It delivers each received byte with a one-cycle valid strobe plus parity and framing error flags.

---
 rtl/uart_rx.sv | 91 +++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, parity and stop bit.
// Delivers each byte with a one-cycle rdsig strobe plus parity/framing error flags.
module uart_rx #(
    parameter logic paritymode = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       parity_err,
    output logic       frame_err,
    output logic       idle
);

    typedef enum logic {StIdle, StRecv} state_e;

    state_e     state;
    logic       rx_m, rx_s, rx_d;
    logic [7:0] cnt;
    logic [7:0] shift;
    logic       par_bit;
    logic [3:0] bit_idx;
    logic       data_pt;

    // Synchronizer resets high so releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Data sample points sit at cnt = 24 + 16k, i.e. low nibble 8, k = cnt[7:4] - 1.
    always_comb begin
        bit_idx = cnt[7:4] - 4'd1;
        data_pt = (cnt[3:0] == 4'd8) && (cnt >= 8'd24) && (cnt <= 8'd136);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= 8'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            dataout    <= 8'h00;
            rdsig      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            idle       <= 1'b0;
        end else begin
            rdsig <= 1'b0;
            case (state)
                StIdle: begin
                    cnt <= 8'd0;
                    if (rx_d && !rx_s) begin
                        state <= StRecv;
                        idle  <= 1'b1;
                    end
                end
                StRecv: begin
                    cnt <= cnt + 8'd1;
                    if (data_pt) shift[bit_idx[2:0]] <= rx_s;
                    if (cnt == 8'd152) par_bit <= rx_s;
                    if (cnt == 8'd7 && rx_s) begin
                        // Start bit gone high at mid-bit: treat as a glitch.
                        state <= StIdle;
                        idle  <= 1'b0;
                        cnt   <= 8'd0;
                    end
                    if (cnt == 8'd168) begin
                        dataout    <= shift;
                        parity_err <= ((^shift) ^ paritymode) != par_bit;
                        frame_err  <= ~rx_s;
                        rdsig      <= 1'b1;
                        idle       <= 1'b0;
                        state      <= StIdle;
                        cnt        <= 8'd0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: even-parity and odd-parity receivers on a shared line.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] dataout0, dataout1;
    logic       rdsig0, rdsig1, pe0, pe1, fe0, fe1, idle0, idle1;

    int vectors = 0;
    int miscompares = 0;
    int idle_cnt = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    uart_rx #(.paritymode(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx), .dataout(dataout0), .rdsig(rdsig0),
        .parity_err(pe0), .frame_err(fe0), .idle(idle0)
    );

    uart_rx #(.paritymode(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx), .dataout(dataout1), .rdsig(rdsig1),
        .parity_err(pe1), .frame_err(fe1), .idle(idle1)
    );

    always #5 clk = ~clk;

    // Record every strobe as {frame_err, parity_err, dataout}.
    always @(negedge clk) begin
        if (rdsig0) q0.push_back({fe0, pe0, dataout0});
        if (rdsig1) q1.push_back({fe1, pe1, dataout1});
        if (idle0) idle_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int stop_len);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rx = par;
        repeat (16) @(negedge clk);
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic clear_mon();
        q0.delete();
        q1.delete();
        idle_cnt = 0;
    endtask

    initial begin
        logic [7:0] lb [4];
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_dataout", {24'd0, dataout0}, 32'h00);
        check("rst_rdsig", {31'd0, rdsig0}, 32'd0);
        check("rst_parity_err", {31'd0, pe0}, 32'd0);
        check("rst_frame_err", {31'd0, fe0}, 32'd0);
        check("rst_idle", {31'd0, idle0}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_release_idle", {31'd0, idle0}, 32'd0);

        // Nominal 0xA5, even weight -> parity bit 0
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("nom_strobes", q0.size(), 32'd1);
        check("nom_entry", {22'd0, q0[0]}, 32'h0A5);
        check("nom_dataout", {24'd0, dataout0}, 32'hA5);
        check("nom_idle_len", idle_cnt, 32'd169);
        check("nom_idle_after", {31'd0, idle0}, 32'd0);

        // Parity error on 0x01 (correct even parity bit would be 1)
        clear_mon();
        send_frame(8'h01, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("perr_entry", {22'd0, q0[0]}, 32'h101);
        check("perr_flag_held", {31'd0, pe0}, 32'd1);
        send_frame(8'h3C, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("perr_clear_strobes", q0.size(), 32'd2);
        check("perr_clear_entry", {22'd0, q0[1]}, 32'h03C);

        // Framing error: 0xFF with stop held low for 40 ticks
        clear_mon();
        send_frame(8'hFF, 1'b0, 1'b0, 40);
        repeat (40) @(negedge clk);
        check("ferr_strobes", q0.size(), 32'd1);
        check("ferr_entry", {22'd0, q0[0]}, 32'h2FF);
        check("ferr_flag_held", {31'd0, fe0}, 32'd1);
        send_frame(8'h55, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("ferr_recover_strobes", q0.size(), 32'd2);
        check("ferr_recover_entry", {22'd0, q0[1]}, 32'h055);

        // False start: 4-tick glitch
        clear_mon();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("fs_strobes", q0.size(), 32'd0);
        check("fs_idle_seen", {31'd0, idle_cnt >= 1}, 32'd1);
        check("fs_idle_bound", {31'd0, idle_cnt <= 9}, 32'd1);
        check("fs_dataout", {24'd0, dataout0}, 32'h55);
        check("fs_flags", {30'd0, fe0, pe0}, 32'd0);

        // Reset mid-frame at cnt ~80, held until the frame is over
        clear_mon();
        fork
            send_frame(8'h96, 1'b0, 1'b1, 16);
            begin
                repeat (84) @(negedge clk);
                check("mid_idle_before", {31'd0, idle0}, 32'd1);
                rst_n = 1'b0;
                #1;
                check("mid_dataout", {24'd0, dataout0}, 32'h00);
                check("mid_idle", {31'd0, idle0}, 32'd0);
            end
        join
        repeat (4) @(negedge clk);
        check("mid_no_strobe", q0.size(), 32'd0);
        check("mid_flags", {30'd0, fe0, pe0}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h96, 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("mid_next_strobes", q0.size(), 32'd1);
        check("mid_next_entry", {22'd0, q0[0]}, 32'h096);

        // Back-to-back even parity (all four bytes have even weight)
        clear_mon();
        for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b0, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("lb0_strobes", q0.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("lb0_entry", {22'd0, q0[i]}, {24'd0, lb[i]});

        // Back-to-back odd parity on the odd-mode receiver
        clear_mon();
        for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("lb1_strobes", q1.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("lb1_entry", {22'd0, q1[i]}, {24'd0, lb[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
